// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: one-entry buffer per requester (A, B), one grant per cycle,
// registered port outputs. Defining REGFILE_WR_ARB_RR_EN selects round-robin, otherwise A has fixed priority.
module regfile_wr_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              idle
);

   logic              full_a_q, full_a_d, full_b_q, full_b_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              grant_a, grant_b;

`ifdef REGFILE_WR_ARB_RR_EN
   // last_q = 1 means B won the most recent contended cycle; reset value lets A win first.
   logic last_q, last_d;

   always_comb begin
      grant_a = full_a_q && (!full_b_q || last_q);
      grant_b = full_b_q && (!full_a_q || !last_q);
      last_d  = last_q;
      if (full_a_q && full_b_q) last_d = grant_b;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end
`else
   always_comb begin
      grant_a = full_a_q;
      grant_b = full_b_q && !full_a_q;
   end
`endif

   // Handshake: a write transfers on an edge where x_valid && x_ready; x_ready comes only from
   // registered state and is high when the buffer is empty or is being drained this cycle.
   assign a_ready = !full_a_q || grant_a;
   assign b_ready = !full_b_q || grant_b;

   always_comb begin
      full_a_d = full_a_q;
      addr_a_d = addr_a_q;
      data_a_d = data_a_q;
      if (a_valid && a_ready) begin
         full_a_d = 1'b1;
         addr_a_d = a_addr;
         data_a_d = a_data;
      end else if (grant_a) begin
         full_a_d = 1'b0;
      end
   end

   always_comb begin
      full_b_d = full_b_q;
      addr_b_d = addr_b_q;
      data_b_d = data_b_q;
      if (b_valid && b_ready) begin
         full_b_d = 1'b1;
         addr_b_d = b_addr;
         data_b_d = b_data;
      end else if (grant_b) begin
         full_b_d = 1'b0;
      end
   end

   // An x0 grant still updates address/data but never raises the strobe.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (grant_a) begin
         wr_en_d   = |addr_a_q;
         wr_addr_d = addr_a_q;
         wr_data_d = data_a_q;
      end else if (grant_b) begin
         wr_en_d   = |addr_b_q;
         wr_addr_d = addr_b_q;
         wr_data_d = data_b_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_a_q  <= 1'b0;
         addr_a_q  <= '0;
         data_a_q  <= '0;
         full_b_q  <= 1'b0;
         addr_b_q  <= '0;
         data_b_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         full_a_q  <= full_a_d;
         addr_a_q  <= addr_a_d;
         data_a_q  <= data_a_d;
         full_b_q  <= full_b_d;
         addr_b_q  <= addr_b_d;
         data_b_q  <= data_b_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign idle    = !full_a_q && !full_b_q && !wr_en_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: per-cycle vector table plus hand sequences for async reset
// and sustained contention; expectations follow REGFILE_WR_ARB_RR_EN when it is defined.
module tb_regfile_wr_arbiter;

`ifdef REGFILE_WR_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk, reset;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [4:0]  a_addr, b_addr, wr_addr;
   logic [31:0] a_data, b_data, wr_data;
   logic        wr_en, idle;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] exp_q[$];

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  ba;
      logic [31:0] bd;
      logic        en;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ar;
      logic        br;
      logic        idl;
   } vec_t;

   vec_t vq[$];

   regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .idle(idle)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
   endtask

   task automatic add(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic en, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ar, input logic br, input logic idl);
      vec_t v;
      v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
      v.en = en; v.wa = wa; v.wd = wd; v.ar = ar; v.br = br; v.idl = idl;
      vq.push_back(v);
   endtask

   task automatic check_outs(input string tag, input logic en, input logic [4:0] wa,
                             input logic [31:0] wd, input logic ar, input logic br,
                             input logic idl);
      check({tag, " wr_en"},   32'(wr_en),   32'(en));
      check({tag, " wr_addr"}, 32'(wr_addr), 32'(wa));
      check({tag, " wr_data"}, wr_data,      wd);
      check({tag, " a_ready"}, 32'(a_ready), 32'(ar));
      check({tag, " b_ready"}, 32'(b_ready), 32'(br));
      check({tag, " idle"},    32'(idle),    32'(idl));
   endtask

   initial begin
      int a_cnt, b_cnt, waited;
      logic [4:0] exp_a;

      // single A write to r5
      add(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
      // simultaneous A (r3) and B (r7)
      add(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
      add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h11,       1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h22,       1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 32'h22,       1'b1, 1'b1, 1'b1);
      // x0 write from B: sequenced but no strobe
      add(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd7, 32'h22,       1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
      // A streaming r1..r6
      for (int i = 1; i <= 6; i++)
         add(1'b1, 5'(i), 32'(32'h100 + i), 1'b0, 5'd0, 32'h0,
             (i != 1), (i == 1) ? 5'd0 : 5'(i - 1),
             (i == 1) ? 32'hFFFFFFFF : 32'(32'h100 + i - 1), 1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h106, 1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 32'h106, 1'b1, 1'b1, 1'b1);
      // same-address contention on r9; round-robin favours B here since A won the last contention
      add(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB, 1'b0, 5'd6, 32'h106, !RR, RR, 1'b0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, RR ? 32'hBB : 32'hAA, 1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, RR ? 32'hAA : 32'hBB, 1'b1, 1'b1, 1'b0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, RR ? 32'hAA : 32'hBB, 1'b1, 1'b1, 1'b1);

      // reset state
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      check_outs("reset", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      reset = 1'b0;

      // vector table: drive at negedge, one posedge, sample at next negedge
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].av, vq[i].aa, vq[i].ad, vq[i].bv, vq[i].ba, vq[i].bd);
         @(negedge clk);
         check_outs($sformatf("vec%0d", i), vq[i].en, vq[i].wa, vq[i].wd,
                    vq[i].ar, vq[i].br, vq[i].idl);
      end

      // reset mid-operation with both buffers loaded and the strobe high
      drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      check("midrst pre wr_en", 32'(wr_en), 32'd1);
      check("midrst pre wr_addr", 32'(wr_addr), 32'd12);
      check("midrst pre idle", 32'(idle), 32'd0);
      #2 reset = 1'b1;
      #1;
      check_outs("midrst async", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("postrst%0d wr_en", i), 32'(wr_en), 32'd0);
         check($sformatf("postrst%0d idle", i), 32'(idle), 32'd1);
      end

      // sustained contention for 8 grants, pointer fresh from reset
      for (int k = 0; k < 8; k++) begin
         exp_a = (RR && (k % 2 == 1)) ? 5'd20 : 5'd10;
         exp_q.push_back(exp_a);
      end
      a_cnt = 0;
      b_cnt = 0;
      drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd20, 32'hB0);
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_a = exp_q.pop_front();
         check($sformatf("contend%0d wr_en", k), 32'(wr_en), 32'd1);
         check($sformatf("contend%0d wr_addr", k), 32'(wr_addr), 32'(exp_a));
         if (wr_en && wr_addr == 5'd10) a_cnt++;
         if (wr_en && wr_addr == 5'd20) b_cnt++;
      end
      check("contend a_count", 32'(a_cnt), RR ? 32'd4 : 32'd8);
      check("contend b_count", 32'(b_cnt), RR ? 32'd4 : 32'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      waited = 0;
      while (!idle && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("contend drain idle", 32'(idle), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
